// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester owns the in-flight access
//   RD_*        : memory read-format codes carried on readop
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam logic [2:0] RD_LB  = 3'd0;
    localparam logic [2:0] RD_LH  = 3'd1;
    localparam logic [2:0] RD_LW  = 3'd2;
    localparam logic [2:0] RD_LBU = 3'd4;
    localparam logic [2:0] RD_LHU = 3'd5;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant.
//   clk, rst : clock and synchronous active-high reset
//   req[1:0] : request vector, bit 0 = IFU, bit 1 = LSU
//   en       : a grant issued while en is high is taken, so last_grant moves to it
//   gnt[1:0] : one-hot grant (all zero when nothing requests)
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    owner_t last_grant_q;
    owner_t last_grant_d;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant_q == OWN_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (en && (gnt != 2'b00)) begin
            last_grant_d = gnt[1] ? OWN_LSU : OWN_IFU;
        end
    end

    // Reset to LSU so the IFU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= OWN_LSU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single data-memory port between the IFU and the LSU.
// A request is accepted in IDLE, its command is latched and driven to the
// memory for LATENCY cycles, the read data is captured in the last of them,
// and it is returned to the owner on a valid/ready response channel.
//   ifu_*  : fetch request (word read) and response
//   lsu_*  : load/store request and response
//   mem_*  : memory port; every mem_* output is 0 outside ACCESS
//
//   state  | meaning
//   IDLE   | port free, req_ready offered to the round-robin grantee
//   ACCESS | mem_valid held with latched command, cnt counts down to 0
//   RESP   | owner's resp_valid high with captured data until resp_ready
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_resp_valid,
    input  logic          ifu_resp_ready,
    output logic [DW-1:0] ifu_rdata,
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic          lsu_wen,
    input  logic [2:0]    lsu_readop,
    input  logic [7:0]    lsu_wmask,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    output logic          lsu_resp_valid,
    input  logic          lsu_resp_ready,
    output logic [DW-1:0] lsu_rdata,
    output logic          mem_valid,
    output logic          mem_wen,
    output logic [2:0]    mem_readop,
    output logic [7:0]    mem_wmask,
    output logic [AW-1:0] mem_raddr,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    arb_state_t    state_q,  state_d;
    owner_t        owner_q,  owner_d;
    logic          wen_q,    wen_d;
    logic [2:0]    readop_q, readop_d;
    logic [7:0]    wmask_q,  wmask_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [DW-1:0] wdata_q,  wdata_d;
    logic [DW-1:0] rdata_q,  rdata_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    logic [1:0] gnt;
    logic       in_idle;
    logic       in_access;
    logic       in_resp;
    logic       owner_resp_ready;

    assign in_idle   = (state_q == IDLE);
    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    assign owner_resp_ready = (owner_q == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;

    // A grant in IDLE is always a handshake, so en is simply "in IDLE".
    mem_arb_rr u_rr (
        .clk (clk),
        .rst (rst),
        .req ({lsu_req_valid, ifu_req_valid}),
        .en  (in_idle),
        .gnt (gnt)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        wen_d    = wen_q;
        readop_d = readop_q;
        wmask_d  = wmask_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt[0]) begin
                    // Fetches are always plain word reads.
                    owner_d  = OWN_IFU;
                    wen_d    = 1'b0;
                    readop_d = RD_LW;
                    wmask_d  = '0;
                    addr_d   = ifu_addr;
                    wdata_d  = '0;
                    cnt_d    = CNT_LOAD;
                    state_d  = ACCESS;
                end else if (gnt[1]) begin
                    owner_d  = OWN_LSU;
                    wen_d    = lsu_wen;
                    readop_d = lsu_readop;
                    wmask_d  = lsu_wmask;
                    addr_d   = lsu_addr;
                    wdata_d  = lsu_wdata;
                    cnt_d    = CNT_LOAD;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (owner_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IFU;
            wen_q    <= 1'b0;
            readop_q <= '0;
            wmask_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wen_q    <= wen_d;
            readop_q <= readop_d;
            wmask_q  <= wmask_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        ifu_req_ready  = in_idle & gnt[0];
        lsu_req_ready  = in_idle & gnt[1];
        ifu_resp_valid = in_resp & (owner_q == OWN_IFU);
        lsu_resp_valid = in_resp & (owner_q == OWN_LSU);
        ifu_rdata      = rdata_q;
        lsu_rdata      = rdata_q;
        mem_valid      = 1'b0;
        mem_wen        = 1'b0;
        mem_readop     = '0;
        mem_wmask      = '0;
        mem_raddr      = '0;
        mem_waddr      = '0;
        mem_wdata      = '0;
        if (in_access) begin
            mem_valid  = 1'b1;
            // Write strobe only in the final access cycle so a store lands once.
            mem_wen    = wen_q & (cnt_q == '0);
            mem_readop = readop_q;
            mem_wmask  = wmask_q;
            mem_raddr  = addr_q;
            mem_waddr  = addr_q;
            mem_wdata  = wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 runs with LATENCY=1, instance 1 with
// LATENCY=3. Each has its own byte-array memory stub and a transaction-level
// model (phase = cycles since acceptance) checked every cycle.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst            [2];
    logic        ifu_req_valid  [2];
    logic        ifu_req_ready  [2];
    logic [31:0] ifu_addr       [2];
    logic        ifu_resp_valid [2];
    logic        ifu_resp_ready [2];
    logic [31:0] ifu_rdata      [2];
    logic        lsu_req_valid  [2];
    logic        lsu_req_ready  [2];
    logic        lsu_wen        [2];
    logic [2:0]  lsu_readop     [2];
    logic [7:0]  lsu_wmask      [2];
    logic [31:0] lsu_addr       [2];
    logic [31:0] lsu_wdata      [2];
    logic        lsu_resp_valid [2];
    logic        lsu_resp_ready [2];
    logic [31:0] lsu_rdata      [2];
    logic        mem_valid      [2];
    logic        mem_wen        [2];
    logic [2:0]  mem_readop     [2];
    logic [7:0]  mem_wmask      [2];
    logic [31:0] mem_raddr      [2];
    logic [31:0] mem_waddr      [2];
    logic [31:0] mem_wdata      [2];
    logic [31:0] mem_rdata      [2];

    mem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) u_l1 (
        .clk(clk), .rst(rst[0]),
        .ifu_req_valid(ifu_req_valid[0]), .ifu_req_ready(ifu_req_ready[0]), .ifu_addr(ifu_addr[0]),
        .ifu_resp_valid(ifu_resp_valid[0]), .ifu_resp_ready(ifu_resp_ready[0]), .ifu_rdata(ifu_rdata[0]),
        .lsu_req_valid(lsu_req_valid[0]), .lsu_req_ready(lsu_req_ready[0]), .lsu_wen(lsu_wen[0]),
        .lsu_readop(lsu_readop[0]), .lsu_wmask(lsu_wmask[0]), .lsu_addr(lsu_addr[0]), .lsu_wdata(lsu_wdata[0]),
        .lsu_resp_valid(lsu_resp_valid[0]), .lsu_resp_ready(lsu_resp_ready[0]), .lsu_rdata(lsu_rdata[0]),
        .mem_valid(mem_valid[0]), .mem_wen(mem_wen[0]), .mem_readop(mem_readop[0]), .mem_wmask(mem_wmask[0]),
        .mem_raddr(mem_raddr[0]), .mem_waddr(mem_waddr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    mem_arbiter #(.LATENCY(3), .AW(32), .DW(32)) u_l3 (
        .clk(clk), .rst(rst[1]),
        .ifu_req_valid(ifu_req_valid[1]), .ifu_req_ready(ifu_req_ready[1]), .ifu_addr(ifu_addr[1]),
        .ifu_resp_valid(ifu_resp_valid[1]), .ifu_resp_ready(ifu_resp_ready[1]), .ifu_rdata(ifu_rdata[1]),
        .lsu_req_valid(lsu_req_valid[1]), .lsu_req_ready(lsu_req_ready[1]), .lsu_wen(lsu_wen[1]),
        .lsu_readop(lsu_readop[1]), .lsu_wmask(lsu_wmask[1]), .lsu_addr(lsu_addr[1]), .lsu_wdata(lsu_wdata[1]),
        .lsu_resp_valid(lsu_resp_valid[1]), .lsu_resp_ready(lsu_resp_ready[1]), .lsu_rdata(lsu_rdata[1]),
        .mem_valid(mem_valid[1]), .mem_wen(mem_wen[1]), .mem_readop(mem_readop[1]), .mem_wmask(mem_wmask[1]),
        .mem_raddr(mem_raddr[1]), .mem_waddr(mem_waddr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    int vectors     = 0;
    int miscompares = 0;

    // Memory stub: byte-addressed, little-endian, 16 KiB window per instance.
    logic [7:0] mem_b [2][16384];

    // Model state: ph = 0 idle, 1..L access cycle number, L+1 response pending.
    bit          m_ok   [2];
    int          m_ph   [2];
    bit          m_own  [2];
    bit          m_last [2];
    bit          m_wen  [2];
    logic [2:0]  m_rop  [2];
    logic [7:0]  m_wm   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    logic [31:0] m_rd   [2];

    function automatic int lat(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] mem_read(input int g, input logic [31:0] a, input logic [2:0] op);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = mem_b[g][14'(a + 32'(i))];
        case (op)
            3'd0:    return {{24{b[0][7]}}, b[0]};
            3'd1:    return {{16{b[1][7]}}, b[1], b[0]};
            3'd2:    return {b[3], b[2], b[1], b[0]};
            3'd4:    return {24'h0, b[0]};
            3'd5:    return {16'h0, b[1], b[0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [2:0] pick_op(input int k);
        case (k)
            0:       return 3'd0;
            1:       return 3'd1;
            2:       return 3'd2;
            3:       return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h8000_0000 | 32'($urandom_range(0, 16383));
    endfunction

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (LATENCY=%0d) t=%0t: got %h expected %h", nm, lat(g), $time, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm, input int g);
        vectors++;
        miscompares++;
        $display("FAIL %s (LATENCY=%0d) t=%0t: bound expired, got no event expected one", nm, lat(g), $time);
    endtask

    // Memory stub, per-cycle compare and model step, all at the falling edge.
    initial begin
        for (int g = 0; g < 2; g++) begin
            for (int a = 0; a < 16384; a++) mem_b[g][a] = 8'h00;
            mem_b[g][0] = 8'h13;
            mem_b[g][1] = 8'h04;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                int L;
                bit gi, gl, acc, rsp;
                L = lat(g);
                gi = 0; gl = 0; acc = 0; rsp = 0;
                mem_rdata[g] = (mem_valid[g] === 1'b1) ? mem_read(g, mem_raddr[g], mem_readop[g]) : 32'h0;
                if (m_ok[g]) begin
                    gi  = (m_ph[g] == 0) && ifu_req_valid[g] && (!lsu_req_valid[g] || m_last[g]);
                    gl  = (m_ph[g] == 0) && lsu_req_valid[g] && (!ifu_req_valid[g] || !m_last[g]);
                    acc = (m_ph[g] >= 1) && (m_ph[g] <= L);
                    rsp = (m_ph[g] == L + 1);
                    chk("ifu_req_ready",  g, ifu_req_ready[g],  gi);
                    chk("lsu_req_ready",  g, lsu_req_ready[g],  gl);
                    chk("mem_valid",      g, mem_valid[g],      acc);
                    chk("mem_wen",        g, mem_wen[g],        acc && (m_ph[g] == L) && m_wen[g]);
                    chk("mem_readop",     g, mem_readop[g],     acc ? m_rop[g] : 3'd0);
                    chk("mem_wmask",      g, mem_wmask[g],      acc ? m_wm[g] : 8'd0);
                    chk("mem_raddr",      g, mem_raddr[g],      acc ? m_addr[g] : 32'd0);
                    chk("mem_waddr",      g, mem_waddr[g],      acc ? m_addr[g] : 32'd0);
                    if (!acc || m_wen[g]) chk("mem_wdata", g, mem_wdata[g], acc ? m_wd[g] : 32'd0);
                    chk("ifu_resp_valid", g, ifu_resp_valid[g], rsp && !m_own[g]);
                    chk("lsu_resp_valid", g, lsu_resp_valid[g], rsp && m_own[g]);
                    if (rsp && !m_own[g]) chk("ifu_rdata", g, ifu_rdata[g], m_rd[g]);
                    if (rsp && m_own[g] && !m_wen[g]) chk("lsu_rdata", g, lsu_rdata[g], m_rd[g]);
                end
                if (rst[g] === 1'b1) begin
                    m_ok[g] = 1; m_ph[g] = 0; m_last[g] = 1; m_rd[g] = 32'h0;
                end else if (m_ok[g]) begin
                    if (m_ph[g] == 0) begin
                        if (gi) begin
                            m_own[g] = 0; m_wen[g] = 0; m_rop[g] = 3'd2; m_wm[g] = 8'h0;
                            m_addr[g] = ifu_addr[g]; m_wd[g] = 32'h0; m_last[g] = 0; m_ph[g] = 1;
                        end else if (gl) begin
                            m_own[g] = 1; m_wen[g] = lsu_wen[g]; m_rop[g] = lsu_readop[g]; m_wm[g] = lsu_wmask[g];
                            m_addr[g] = lsu_addr[g]; m_wd[g] = lsu_wdata[g]; m_last[g] = 1; m_ph[g] = 1;
                        end
                    end else if (m_ph[g] <= L) begin
                        if (m_ph[g] == L) m_rd[g] = mem_read(g, m_addr[g], m_rop[g]);
                        m_ph[g]++;
                    end else if (m_own[g] ? lsu_resp_ready[g] : ifu_resp_ready[g]) begin
                        m_ph[g] = 0;
                    end
                end
                if (mem_valid[g] === 1'b1 && mem_wen[g] === 1'b1) begin
                    for (int i = 0; i < 4; i++)
                        if (mem_wmask[g][i]) mem_b[g][14'((mem_waddr[g] & ~32'h3) + 32'(i))] = mem_wdata[g][8*i +: 8];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int g, input bit lsu, input bit wen, input logic [2:0] op,
                         input logic [7:0] wm, input logic [31:0] a, input logic [31:0] wd);
        bit got;
        got = 0;
        if (lsu) begin
            lsu_req_valid[g] = 1; lsu_wen[g] = wen; lsu_readop[g] = op;
            lsu_wmask[g] = wm; lsu_addr[g] = a; lsu_wdata[g] = wd;
        end else begin
            ifu_req_valid[g] = 1; ifu_addr[g] = a;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = ((lsu ? lsu_req_ready[g] : ifu_req_ready[g]) === 1'b1);
        end
        if (!got) bound_fail("accept_timeout", g);
        tick();
        lsu_req_valid[g] = 0;
        ifu_req_valid[g] = 0;
    endtask

    task automatic wait_resp(input int g, input bit lsu, output int n, output int nv, output int nw,
                             output logic [31:0] d);
        bit seen;
        seen = 0; n = 0; nv = 0; nw = 0; d = 32'h0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (mem_valid[g] === 1'b1) nv++;
            if (mem_wen[g] === 1'b1) nw++;
            if ((lsu ? lsu_resp_valid[g] : ifu_resp_valid[g]) === 1'b1) begin
                seen = 1;
                d = lsu ? lsu_rdata[g] : ifu_rdata[g];
            end
        end
        if (!seen) bound_fail("resp_timeout", g);
        tick();
    endtask

    task automatic run(input int g);
        int L, n, nv, nw, ng;
        int grants [3];
        logic [31:0] d;
        L = lat(g);
        rst[g] = 1; ifu_req_valid[g] = 0; lsu_req_valid[g] = 0; ifu_addr[g] = 0;
        lsu_wen[g] = 0; lsu_readop[g] = 0; lsu_wmask[g] = 0; lsu_addr[g] = 0; lsu_wdata[g] = 0;
        ifu_resp_ready[g] = 1; lsu_resp_ready[g] = 1;
        repeat (3) tick();
        rst[g] = 0;
        tick();

        // IFU-only fetch
        issue(g, 0, 0, 3'd2, 8'h0, 32'h8000_0000, 32'h0);
        wait_resp(g, 0, n, nv, nw, d);
        chk("ifu_latency", g, n, L + 1);
        chk("ifu_fetch_data", g, d, 32'h0000_0413);
        chk("ifu_mem_valid_cycles", g, nv, L);

        // Ties from reset alternate IFU, LSU, IFU
        rst[g] = 1; tick(); tick(); rst[g] = 0;
        ifu_req_valid[g] = 1; ifu_addr[g] = 32'h8000_0000;
        lsu_req_valid[g] = 1; lsu_wen[g] = 0; lsu_readop[g] = 3'd2; lsu_addr[g] = 32'h8000_0004;
        ng = 0;
        for (int i = 0; i < 60 && ng < 3; i++) begin
            @(negedge clk);
            if (ifu_req_ready[g] === 1'b1) begin grants[ng] = 0; ng++; end
            else if (lsu_req_ready[g] === 1'b1) begin grants[ng] = 1; ng++; end
        end
        if (ng < 3) bound_fail("tie_grant_timeout", g);
        tick();
        ifu_req_valid[g] = 0; lsu_req_valid[g] = 0;
        repeat (L + 4) tick();
        if (ng == 3) begin
            chk("tie_grant_1", g, grants[0], 0);
            chk("tie_grant_2", g, grants[1], 1);
            chk("tie_grant_3", g, grants[2], 0);
        end

        // Store then sign/zero-extended byte loads
        issue(g, 1, 1, 3'd2, 8'h0F, 32'h8000_1000, 32'hDEAD_BEEF);
        wait_resp(g, 1, n, nv, nw, d);
        chk("store_latency", g, n, L + 1);
        chk("store_mem_valid_cycles", g, nv, L);
        chk("store_mem_wen_cycles", g, nw, 1);
        issue(g, 1, 0, 3'd0, 8'h0, 32'h8000_1003, 32'h0);
        wait_resp(g, 1, n, nv, nw, d);
        chk("lb_data", g, d, 32'hFFFF_FFDE);
        issue(g, 1, 0, 3'd4, 8'h0, 32'h8000_1003, 32'h0);
        wait_resp(g, 1, n, nv, nw, d);
        chk("lbu_data", g, d, 32'h0000_00DE);

        // Response backpressure with a competing request pending
        lsu_resp_ready[g] = 0;
        issue(g, 1, 0, 3'd2, 8'h0, 32'h8000_1000, 32'h0);
        wait_resp(g, 1, n, nv, nw, d);
        chk("bp_first_data", g, d, 32'hDEAD_BEEF);
        ifu_req_valid[g] = 1; ifu_addr[g] = 32'h8000_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_resp_valid", g, lsu_resp_valid[g], 1'b1);
            chk("bp_rdata", g, lsu_rdata[g], 32'hDEAD_BEEF);
            chk("bp_ifu_req_ready", g, ifu_req_ready[g], 1'b0);
        end
        tick();
        ifu_req_valid[g] = 0; lsu_resp_ready[g] = 1;
        repeat (3) tick();

        // Reset during ACCESS aborts silently
        issue(g, 1, 0, 3'd2, 8'h0, 32'h8000_1000, 32'h0);
        rst[g] = 1;
        tick();
        rst[g] = 0;
        for (int i = 0; i < L + 3; i++) begin
            @(negedge clk);
            chk("abort_mem_valid", g, mem_valid[g], 1'b0);
            chk("abort_resp_valid", g, lsu_resp_valid[g], 1'b0);
        end
        tick();
        issue(g, 0, 0, 3'd2, 8'h0, 32'h8000_0000, 32'h0);
        wait_resp(g, 0, n, nv, nw, d);
        chk("post_abort_latency", g, n, L + 1);
        chk("post_abort_data", g, d, 32'h0000_0413);

        // Randomized traffic, checked cycle by cycle by the model
        for (int c = 0; c < 1500; c++) begin
            rst[g]            = ($urandom_range(0, 249) == 0);
            ifu_req_valid[g]  = ($urandom_range(0, 2) != 0);
            ifu_addr[g]       = rand_addr();
            lsu_req_valid[g]  = ($urandom_range(0, 2) != 0);
            lsu_wen[g]        = 1'($urandom_range(0, 1));
            lsu_readop[g]     = pick_op(int'($urandom_range(0, 4)));
            lsu_wmask[g]      = 8'($urandom_range(0, 255));
            lsu_addr[g]       = rand_addr();
            lsu_wdata[g]      = 32'($urandom());
            ifu_resp_ready[g] = ($urandom_range(0, 3) != 0);
            lsu_resp_ready[g] = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst[g] = 0; ifu_req_valid[g] = 0; lsu_req_valid[g] = 0;
        ifu_resp_ready[g] = 1; lsu_resp_ready[g] = 1;
        repeat (10) tick();
    endtask

    initial begin
        fork
            run(0);
            run(1);
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
